// File: rtl/reg_window_param_if.sv
// reg_window_param_if: operation/read bus for reg_window_param
// master drives start/mode/addr/data_i/rd_addr; slave returns read data, evict word, occupancy and error flags
interface reg_window_param_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);
    logic             start;
    logic [1:0]       mode;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data_i;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] evict_o;
    logic             evict_valid_o;
    logic [AW:0]      count_o;
    logic             full_o;
    logic             empty_o;
    logic             err_o;
    modport master (
        output start, mode, addr, data_i, rd_addr,
        input  rd_data, evict_o, evict_valid_o, count_o, full_o, empty_o, err_o
    );
    modport slave (
        input  start, mode, addr, data_i, rd_addr,
        output rd_data, evict_o, evict_valid_o, count_o, full_o, empty_o, err_o
    );
endinterface

// File: rtl/reg_window_param.sv
// reg_window_param: DEPTH x WIDTH shift/write register window with eviction, occupancy count and async reset
// ports: CLK clock, RST async active-high reset, bus slave modport (op inputs, comb read, registered evict/count/err)
module reg_window_param #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input logic CLK,
    input logic RST,
    reg_window_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [1:0] MODE_SHIFT = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;
    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [WIDTH-1:0] entry_d [DEPTH];
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] evict_q, evict_d;
    logic             evict_valid_q, evict_valid_d;
    logic             err_q, err_d;
    logic             full;
    assign full = count_q == DEPTH_C;
    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        evict_d = evict_q;
        evict_valid_d = 1'b0;
        err_d = 1'b0;
        if (bus.start) begin
            case (bus.mode)
                MODE_SHIFT: begin
                    for (int i = 1; i < DEPTH; i++) entry_d[i] = entry_q[i-1];
                    entry_d[0] = bus.data_i;
                    if (full) begin
                        evict_d = entry_q[DEPTH-1];
                        evict_valid_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                MODE_WRITE: begin
                    // addresses past DEPTH only exist for non-power-of-two depths
                    if ({1'b0, bus.addr} < DEPTH_C) entry_d[bus.addr] = bus.data_i;
                    else err_d = 1'b1;
                end
                MODE_CLEAR: begin
                    for (int i = 0; i < DEPTH; i++) entry_d[i] = '0;
                    count_d = '0;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            count_q <= '0;
            evict_q <= '0;
            evict_valid_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
            evict_q <= evict_d;
            evict_valid_q <= evict_valid_d;
            err_q <= err_d;
        end
    end
    // reads see the registered array, so a same-cycle op is not visible until after the edge
    assign bus.rd_data = ({1'b0, bus.rd_addr} < DEPTH_C) ? entry_q[bus.rd_addr] : '0;
    assign bus.evict_o = evict_q;
    assign bus.evict_valid_o = evict_valid_q;
    assign bus.count_o = count_q;
    assign bus.full_o = full;
    assign bus.empty_o = count_q == '0;
    assign bus.err_o = err_q;
endmodule

// File: tb/tb_reg_window_param.sv
// tb_reg_window_param: directed self-checking bench for reg_window_param at DEPTH=16 and DEPTH=12
module tb_reg_window_param;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int pass_cnt = 0;
    int total_cnt = 0;
    reg_window_param_if #(.WIDTH(32), .DEPTH(16)) b16 ();
    reg_window_param_if #(.WIDTH(32), .DEPTH(12)) b12 ();
    reg_window_param #(.WIDTH(32), .DEPTH(16)) u16 (.CLK(CLK), .RST(RST), .bus(b16));
    reg_window_param #(.WIDTH(32), .DEPTH(12)) u12 (.CLK(CLK), .RST(RST), .bus(b12));
    always #5 CLK = ~CLK;

    task automatic op16(input logic s, input logic [1:0] m, input logic [3:0] a, input logic [31:0] d);
        @(negedge CLK);
        b16.start = s;
        b16.mode = m;
        b16.addr = a;
        b16.data_i = d;
        @(posedge CLK);
        #1;
        b16.start = 1'b0;
    endtask

    task automatic op12(input logic s, input logic [1:0] m, input logic [3:0] a, input logic [31:0] d);
        @(negedge CLK);
        b12.start = s;
        b12.mode = m;
        b12.addr = a;
        b12.data_i = d;
        @(posedge CLK);
        #1;
        b12.start = 1'b0;
    endtask

    task automatic rd16(input logic [3:0] a, output logic [31:0] v);
        b16.rd_addr = a;
        #1;
        v = b16.rd_data;
    endtask

    task automatic rd12(input logic [3:0] a, output logic [31:0] v);
        b12.rd_addr = a;
        #1;
        v = b12.rd_data;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        #12;
        rd16(4'd3, v);
        total_cnt++;
        if (b16.count_o !== 5'd0 || b16.empty_o !== 1'b1 || b16.full_o !== 1'b0)
            $display("FAIL reset_flags count=%0d empty=%b full=%b want 0/1/0", b16.count_o, b16.empty_o, b16.full_o);
        else pass_cnt++;
        total_cnt++;
        if (b16.evict_valid_o !== 1'b0 || b16.err_o !== 1'b0 || b16.evict_o !== 32'd0 || v !== 32'd0)
            $display("FAIL reset_outs ev=%b err=%b evict=%h rd=%h want zeros", b16.evict_valid_o, b16.err_o, b16.evict_o, v);
        else pass_cnt++;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_fill;
        logic [31:0] v;
        int bad = 0;
        for (int k = 1; k <= 16; k++) begin
            op16(1'b1, 2'b01, 4'd0, 32'(k));
            if (b16.evict_valid_o !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL fill_no_evict pulses=%0d want 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (b16.count_o !== 5'd16 || b16.full_o !== 1'b1 || b16.empty_o !== 1'b0)
            $display("FAIL fill_count count=%0d full=%b empty=%b want 16/1/0", b16.count_o, b16.full_o, b16.empty_o);
        else pass_cnt++;
        rd16(4'd0, v);
        total_cnt++;
        if (v !== 32'd16) $display("FAIL fill_rd0 got=%0d want 16", v);
        else pass_cnt++;
        rd16(4'd15, v);
        total_cnt++;
        if (v !== 32'd1) $display("FAIL fill_rd15 got=%0d want 1", v);
        else pass_cnt++;
    endtask

    task automatic test_evict;
        logic [31:0] v;
        op16(1'b1, 2'b01, 4'd0, 32'hDEADBEEF);
        total_cnt++;
        if (b16.evict_valid_o !== 1'b1 || b16.evict_o !== 32'd1)
            $display("FAIL evict_pulse ev=%b evict=%h want 1/00000001", b16.evict_valid_o, b16.evict_o);
        else pass_cnt++;
        total_cnt++;
        if (b16.count_o !== 5'd16) $display("FAIL evict_count got=%0d want 16", b16.count_o);
        else pass_cnt++;
        rd16(4'd0, v);
        total_cnt++;
        if (v !== 32'hDEADBEEF) $display("FAIL evict_rd0 got=%h want deadbeef", v);
        else pass_cnt++;
        op16(1'b1, 2'b00, 4'd0, 32'h0);
        total_cnt++;
        if (b16.evict_valid_o !== 1'b0 || b16.evict_o !== 32'd1)
            $display("FAIL evict_one_cycle ev=%b evict=%h want 0/00000001", b16.evict_valid_o, b16.evict_o);
        else pass_cnt++;
    endtask

    task automatic test_write_gating;
        logic [31:0] v;
        op16(1'b1, 2'b10, 4'd5, 32'hA5A5A5A5);
        rd16(4'd5, v);
        total_cnt++;
        if (v !== 32'hA5A5A5A5 || b16.count_o !== 5'd16 || b16.err_o !== 1'b0)
            $display("FAIL write_5 rd=%h count=%0d err=%b want a5a5a5a5/16/0", v, b16.count_o, b16.err_o);
        else pass_cnt++;
        rd16(4'd4, v);
        total_cnt++;
        if (v !== 32'd13) $display("FAIL write_neighbour rd4=%0d want 13", v);
        else pass_cnt++;
        op16(1'b0, 2'b10, 4'd5, 32'h12345678);
        op16(1'b0, 2'b01, 4'd0, 32'h12345678);
        op16(1'b0, 2'b11, 4'd0, 32'h0);
        rd16(4'd5, v);
        total_cnt++;
        if (v !== 32'hA5A5A5A5 || b16.count_o !== 5'd16 || b16.evict_o !== 32'd1)
            $display("FAIL start_gate rd5=%h count=%0d evict=%h want a5a5a5a5/16/00000001", v, b16.count_o, b16.evict_o);
        else pass_cnt++;
    endtask

    task automatic test_no_write_through;
        @(negedge CLK);
        b16.rd_addr = 4'd0;
        b16.start = 1'b1;
        b16.mode = 2'b01;
        b16.data_i = 32'h55;
        #1;
        total_cnt++;
        if (b16.rd_data !== 32'hDEADBEEF) $display("FAIL pre_edge_rd0 got=%h want deadbeef", b16.rd_data);
        else pass_cnt++;
        @(posedge CLK);
        #1;
        b16.start = 1'b0;
        total_cnt++;
        if (b16.rd_data !== 32'h55 || b16.evict_o !== 32'd2 || b16.evict_valid_o !== 1'b1)
            $display("FAIL post_edge rd0=%h evict=%h ev=%b want 00000055/00000002/1", b16.rd_data, b16.evict_o, b16.evict_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_clear;
        logic [31:0] v;
        int bad = 0;
        op16(1'b1, 2'b11, 4'd0, 32'hFFFFFFFF);
        total_cnt++;
        if (b16.count_o !== 5'd0 || b16.empty_o !== 1'b1 || b16.full_o !== 1'b0 || b16.evict_valid_o !== 1'b0)
            $display("FAIL clear_flags count=%0d empty=%b full=%b ev=%b want 0/1/0/0", b16.count_o, b16.empty_o, b16.full_o, b16.evict_valid_o);
        else pass_cnt++;
        total_cnt++;
        if (b16.evict_o !== 32'd2) $display("FAIL clear_evict_kept got=%h want 00000002", b16.evict_o);
        else pass_cnt++;
        for (int a = 0; a < 16; a++) begin
            rd16(4'(a), v);
            if (v !== 32'd0) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL clear_entries nonzero=%0d want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_out_of_range;
        logic [31:0] v;
        op12(1'b1, 2'b01, 4'd0, 32'h11);
        op12(1'b1, 2'b01, 4'd0, 32'h22);
        op12(1'b1, 2'b01, 4'd0, 32'h33);
        op12(1'b1, 2'b10, 4'd13, 32'hFFFF);
        total_cnt++;
        if (b12.err_o !== 1'b1) $display("FAIL oor_err got=%b want 1", b12.err_o);
        else pass_cnt++;
        op12(1'b1, 2'b00, 4'd0, 32'h0);
        total_cnt++;
        if (b12.err_o !== 1'b0) $display("FAIL oor_err_one_cycle got=%b want 0", b12.err_o);
        else pass_cnt++;
        rd12(4'd0, v);
        total_cnt++;
        if (v !== 32'h33 || b12.count_o !== 5'd3) $display("FAIL oor_unchanged rd0=%h count=%0d want 00000033/3", v, b12.count_o);
        else pass_cnt++;
        rd12(4'd13, v);
        total_cnt++;
        if (v !== 32'd0) $display("FAIL oor_rd13 got=%h want 0", v);
        else pass_cnt++;
        op12(1'b1, 2'b10, 4'd11, 32'hBEEF);
        rd12(4'd11, v);
        total_cnt++;
        if (v !== 32'hBEEF || b12.err_o !== 1'b0) $display("FAIL last_entry_write rd11=%h err=%b want 0000beef/0", v, b12.err_o);
        else pass_cnt++;
    endtask

    task automatic test_async_reset;
        logic [31:0] v;
        op16(1'b1, 2'b01, 4'd0, 32'hA1);
        op16(1'b1, 2'b01, 4'd0, 32'hA2);
        op16(1'b1, 2'b01, 4'd0, 32'hA3);
        total_cnt++;
        if (b16.count_o !== 5'd3) $display("FAIL burst_count got=%0d want 3", b16.count_o);
        else pass_cnt++;
        @(negedge CLK);
        b16.start = 1'b1;
        b16.mode = 2'b01;
        b16.data_i = 32'h7;
        b16.rd_addr = 4'd0;
        #1;
        RST = 1'b1;
        #1;
        total_cnt++;
        if (b16.count_o !== 5'd0 || b16.empty_o !== 1'b1 || b16.rd_data !== 32'd0 || b16.evict_o !== 32'd0 || b16.evict_valid_o !== 1'b0)
            $display("FAIL async_reset count=%0d empty=%b rd0=%h evict=%h ev=%b want 0/1/0/0/0", b16.count_o, b16.empty_o, b16.rd_data, b16.evict_o, b16.evict_valid_o);
        else pass_cnt++;
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        b16.start = 1'b0;
        rd16(4'd0, v);
        total_cnt++;
        if (b16.count_o !== 5'd1 || v !== 32'h7) $display("FAIL after_release count=%0d rd0=%h want 1/00000007", b16.count_o, v);
        else pass_cnt++;
    endtask

    initial begin
        b16.start = 1'b0; b16.mode = 2'b00; b16.addr = '0; b16.data_i = '0; b16.rd_addr = '0;
        b12.start = 1'b0; b12.mode = 2'b00; b12.addr = '0; b12.data_i = '0; b12.rd_addr = '0;
        test_reset();
        test_fill();
        test_evict();
        test_write_gating();
        test_no_write_through();
        test_clear();
        test_out_of_range();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/reg_window_param.md
REG_WINDOW_PARAM -- requirements
Module: reg_window_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the bit width of each entry.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of entries (legal range 2..64).
REQ-003 SHALL have derived parameter AW = clog2(DEPTH), meaning the address width.
REQ-004 SHALL have port CLK, input, 1 bit, meaning the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit, meaning an asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit, meaning the operation enable; when low, the block holds all state.
REQ-007 SHALL have port mode, input, 2 bits, meaning the operation select: 00 HOLD, 01 SHIFT, 10 WRITE, 11 CLEAR.
REQ-008 SHALL have port addr, input, AW bits, meaning the WRITE target entry.
REQ-009 SHALL have port data_i, input, WIDTH bits, meaning the SHIFT/WRITE data.
REQ-010 SHALL have port rd_addr, input, AW bits, meaning the read-port select.
REQ-011 SHALL have port rd_data, output, WIDTH bits, meaning the combinational read of entry[rd_addr].
REQ-012 SHALL have port evict_o, output, WIDTH bits, meaning the registered word shifted out of entry[DEPTH-1].
REQ-013 SHALL have port evict_valid_o, output, 1 bit, meaning a single-cycle pulse qualifying evict_o.
REQ-014 SHALL have port count_o, output, AW+1 bits, meaning the number of valid entries, 0..DEPTH.
REQ-015 SHALL have port full_o, output, 1 bit, meaning count_o == DEPTH.
REQ-016 SHALL have port empty_o, output, 1 bit, meaning count_o == 0.
REQ-017 SHALL have port err_o, output, 1 bit, meaning a single-cycle pulse flagging an out-of-range WRITE.

Function
REQ-018 SHALL hold all entries, count, and evict_o whenever start=0, regardless of mode; evict_valid_o and err_o SHALL be 0 in the following cycle.
REQ-019 SHALL, with start=1 and mode=HOLD, keep all state unchanged and drive evict_valid_o=0 and err_o=0 next cycle.
REQ-020 SHALL, on start=1 with mode=SHIFT, load entry[0]<=data_i and entry[i]<=entry[i-1] for i=1..DEPTH-1, all in one cycle.
REQ-021 SHALL, on SHIFT with count<DEPTH, increment count by 1 and keep evict_valid_o=0.
REQ-022 SHALL, on SHIFT with count==DEPTH, keep count saturated at DEPTH, load evict_o<=old entry[DEPTH-1], and set evict_valid_o=1 for exactly one cycle.
REQ-023 SHALL, on start=1 with mode=WRITE and addr<DEPTH, load entry[addr]<=data_i with count unchanged.
REQ-024 SHALL, on WRITE with addr>=DEPTH (non-power-of-two DEPTH), change no entry and pulse err_o=1 for one cycle.
REQ-025 SHALL, on start=1 with mode=CLEAR, zero all entries and count in one cycle, with evict_o unchanged and evict_valid_o=0.
REQ-026 SHALL drive rd_data=entry[rd_addr] combinationally, and 0 when rd_addr>=DEPTH.
REQ-027 SHALL derive full_o and empty_o combinationally from the count register.
REQ-028 SHALL make a rd_addr read in the same cycle as a SHIFT/WRITE/CLEAR return the pre-edge value (no write-through).
REQ-029 SHALL give latency 1 cycle from the operation edge to updated entries, count, evict_o, evict_valid_o, and err_o.
REQ-030 SHALL evaluate all ops on every qualifying edge, including back-to-back SHIFTs at full rate, with no bubble.

Reset
REQ-031 SHALL, while RST=1, immediately force all entries, count_o, evict_o, evict_valid_o, and err_o to 0, with empty_o=1 and full_o=0, independent of CLK.
REQ-032 SHALL, on RST asserted mid-operation, discard the in-flight op; the first edge after RST deasserts SHALL execute the op then presented.

Verification
REQ-033 SHALL cover the fill case (WIDTH=32, DEPTH=16): 16 SHIFTs of data_i=k (k=1..16) -> count_o=16, full_o=1, rd_data@rd_addr=0 is 16, rd_data@rd_addr=15 is 1, evict_valid_o never 1.
REQ-034 SHALL cover the evict case: a 17th SHIFT of 0xDEADBEEF when full -> evict_o=1, evict_valid_o=1 for one cycle, entry0=0xDEADBEEF, count_o stays 16.
REQ-035 SHALL cover WRITE and start gating: WRITE addr=5 data 0xA5A5A5A5 -> rd_data@5=0xA5A5A5A5, count_o unchanged; the same op with start=0 -> no change.
REQ-036 SHALL cover the out-of-range WRITE: DEPTH=12, WRITE addr=13 -> err_o pulses 1 cycle, all entries unchanged; rd_addr=13 -> rd_data=0.
REQ-037 SHALL cover CLEAR: CLEAR after fill -> count_o=0, empty_o=1, all rd_data=0, evict_valid_o=0.
REQ-038 SHALL cover asynchronous reset: RST pulse between clock edges during a SHIFT burst -> outputs 0 before the next CLK edge; the first SHIFT after release gives count_o=1.
